eth_hdr_rx: RTL
===============

// Module: eth_hdr_rx
// PURPOSE
//   Ethernet header parser directly downstream of the GMII RX stage. Consumes the
//   byte stream (from byte after SFD), extracts dest MAC, src MAC and EtherType
//   (first 14 bytes), forwards remaining bytes as payload AXI-Stream to upper layers.
//   Optional dest-MAC filter. No backpressure: the upstream stage has no tready.
// PARAMETERS
//   DATA_W     8                  stream width; only 8 supported
//   FILTER_EN  0                  1: drop frames whose dest != LOCAL_MAC and != broadcast
//   LOCAL_MAC  48'h02_00_00_00_00_01  station address for filter
// PORTS
//   clk            in   1       clock
//   rst_n          in   1       synchronous active-low reset
//   s_axis_tdata   in   DATA_W  frame byte
//   s_axis_tvalid  in   1       byte valid
//   s_axis_tlast   in   1       last byte of frame / abort marker
//   s_axis_tuser   in   1       frame error
//   m_hdr_valid    out  1       1-cycle pulse: header fields valid
//   m_dest_mac     out  48      destination MAC, first wire byte in [47:40]
//   m_src_mac      out  48      source MAC, first wire byte in [47:40]
//   m_eth_type     out  16      EtherType, byte 12 in [15:8]
//   m_axis_tdata   out  DATA_W  payload byte
//   m_axis_tvalid  out  1       payload valid
//   m_axis_tlast   out  1       last payload beat
//   m_axis_tuser   out  1       payload frame bad
//   er_runt        out  1       pulse: frame ended inside header
//   er_filtered    out  1       pulse: frame dropped by MAC filter
//   er_bad_frame   out  1       pulse: upstream error seen in frame
// BEHAVIOUR
//   Reset: state IDLE, byte counter 0, all outputs 0 (hdr fields 0). All outputs registered.
//   Beat = s_axis_tvalid. Abort = s_axis_tlast & s_axis_tuser, honoured even with tvalid=0.
//   States: IDLE, HDR, PAYLOAD, DROP. 4-bit counter cnt counts header bytes 0..13.
//   IDLE: first beat -> store as byte 0, cnt=1, go HDR.
//   HDR: each beat stored at byte cnt, cnt++. Bytes 0-5 dest, 6-11 src, 12-13 type.
//     - After byte 5, FILTER_EN=1 and dest mismatch (not LOCAL_MAC, not all-ones):
//       er_filtered pulse next cycle, go DROP (or IDLE if that byte had tlast).
//     - Byte 13 accepted: m_hdr_valid pulses next cycle with all fields stable; go PAYLOAD;
//       if byte 13 had tlast, go IDLE, no payload beats (header-only frame legal).
//     - tlast/abort before byte 13: er_runt pulse (plus er_bad_frame if tuser), no
//       m_hdr_valid, go IDLE.
//   PAYLOAD: each beat forwarded with 1-cycle latency: tdata/tlast/tuser copied.
//     - tlast beat -> IDLE after forwarding. tuser=1 -> also er_bad_frame pulse.
//     - Abort with tvalid=0: emit m_axis_tvalid=1, tlast=1, tuser=1, tdata=0; er_bad_frame; IDLE.
//   DROP: discard beats, no outputs; tlast/abort -> IDLE.
//   Header fields hold until next m_hdr_valid; overwritten only by next frame's bytes.
//   Beat in same cycle as return to IDLE is impossible (one beat per cycle); next frame's
//   byte 0 may arrive the cycle after tlast and must be captured.
//   Mid-frame reset: return to IDLE, outputs 0; remainder of frame treated as a new frame.
//   m_axis_tvalid and m_hdr_valid never both asserted for the same byte.
// TESTING
//   60-byte frame dest FF..FF, src 02..0A, type 0800, payload 00..2D -> hdr_valid once
//     (dest=48'hFFFFFFFFFFFF, type=16'h0800), 46 payload beats, tlast on 46th, tuser=0.
//   10-byte frame with tlast on byte 9 -> er_runt pulse, no hdr_valid, no payload beats.
//   FILTER_EN=1, dest 02..03 != LOCAL_MAC, 64 bytes -> er_filtered once, zero outputs.
//   Abort (tvalid=0,tlast=1,tuser=1) at payload byte 20 -> 20 good beats then
//     tvalid/tlast/tuser=1 beat, er_bad_frame pulse; next frame parsed normally.
//   14-byte header-only frame, then back-to-back 64-byte frame next cycle -> two
//     hdr_valid pulses, 0 then 50 payload beats.
//   rst_n low for 1 cycle at payload byte 5 -> outputs 0; following bytes parsed as new header.

Source files
------------

// File: rtl/eth_hdr_rx.sv
// Ethernet header parser: strips dest/src MAC and EtherType from the post-SFD byte
// stream, forwards the payload as AXI-Stream, optionally filters on destination MAC.
module eth_hdr_rx #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          FILTER_EN = 1'b0,
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic              m_hdr_valid,
  output logic [47:0]       m_dest_mac,
  output logic [47:0]       m_src_mac,
  output logic [15:0]       m_eth_type,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              er_runt,
  output logic              er_filtered,
  output logic              er_bad_frame
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MAC_W  = 48;
  localparam int unsigned TYPE_W = 16;
  localparam logic [CNT_W-1:0] LAST_DEST = CNT_W'(5);
  localparam logic [CNT_W-1:0] LAST_SRC  = CNT_W'(11);
  localparam logic [CNT_W-1:0] LAST_HDR  = CNT_W'(13);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_DROP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_beat;
  logic              w_abort;
  logic              w_hdr_we;
  logic [MAC_W-1:0]  w_dest_cand;
  logic              w_filt_hit;

  logic              w_hdr_valid;
  logic [DATA_W-1:0] w_tdata;
  logic              w_tvalid;
  logic              w_tlast;
  logic              w_tuser;
  logic              w_runt;
  logic              w_filt;
  logic              w_bad;

  assign w_beat  = s_axis_tvalid;
  assign w_abort = s_axis_tlast & s_axis_tuser;

  // Destination as it will look once the current (6th) byte is shifted in
  assign w_dest_cand = {m_dest_mac[MAC_W-DATA_W-1:0], s_axis_tdata};
  assign w_filt_hit  = FILTER_EN && (w_dest_cand != LOCAL_MAC) && (w_dest_cand != '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hdr_we    = 1'b0;
    w_hdr_valid = 1'b0;
    w_tdata     = '0;
    w_tvalid    = 1'b0;
    w_tlast     = 1'b0;
    w_tuser     = 1'b0;
    w_runt      = 1'b0;
    w_filt      = 1'b0;
    w_bad       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          w_hdr_we = 1'b1;
          if (s_axis_tlast) begin
            w_runt    = 1'b1;
            w_bad     = s_axis_tuser;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (w_beat) begin
          w_hdr_we  = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if ((r_cnt == LAST_DEST) && w_filt_hit) begin
            w_filt      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = s_axis_tlast ? ST_IDLE : ST_DROP;
          end else if (r_cnt == LAST_HDR) begin
            w_hdr_valid = 1'b1;
            w_bad       = s_axis_tlast & s_axis_tuser;
            w_cnt_nxt   = '0;
            w_state_nxt = s_axis_tlast ? ST_IDLE : ST_PAYLOAD;
          end else if (s_axis_tlast) begin
            w_runt      = 1'b1;
            w_bad       = s_axis_tuser;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_abort) begin
          w_runt      = 1'b1;
          w_bad       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (w_beat) begin
          w_tvalid = 1'b1;
          w_tdata  = s_axis_tdata;
          w_tlast  = s_axis_tlast;
          w_tuser  = s_axis_tuser;
          w_bad    = s_axis_tuser;
          if (s_axis_tlast) w_state_nxt = ST_IDLE;
        end else if (w_abort) begin
          // Abort with no data still closes the downstream packet as bad
          w_tvalid    = 1'b1;
          w_tlast     = 1'b1;
          w_tuser     = 1'b1;
          w_bad       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if ((w_beat & s_axis_tlast) | w_abort) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output and header-field registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_hdr_valid   <= 1'b0;
      m_dest_mac    <= '0;
      m_src_mac     <= '0;
      m_eth_type    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      er_runt       <= 1'b0;
      er_filtered   <= 1'b0;
      er_bad_frame  <= 1'b0;
    end else begin
      m_hdr_valid   <= w_hdr_valid;
      m_axis_tdata  <= w_tdata;
      m_axis_tvalid <= w_tvalid;
      m_axis_tlast  <= w_tlast;
      m_axis_tuser  <= w_tuser;
      er_runt       <= w_runt;
      er_filtered   <= w_filt;
      er_bad_frame  <= w_bad;
      if (w_hdr_we) begin
        if (r_cnt <= LAST_DEST)
          m_dest_mac <= {m_dest_mac[MAC_W-DATA_W-1:0], s_axis_tdata};
        else if (r_cnt <= LAST_SRC)
          m_src_mac  <= {m_src_mac[MAC_W-DATA_W-1:0], s_axis_tdata};
        else
          m_eth_type <= {m_eth_type[TYPE_W-DATA_W-1:0], s_axis_tdata};
      end
    end
  end

endmodule
